// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the execute stage: opcodes, funct3 codes and the bubble instruction.
package rv32_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU = 7'b0010011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I integer ALU; alt selects SUB for ADD and arithmetic shift for SR.
module rv32_alu
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      funct3,
  input  logic            alt,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = op_b[SHW-1:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_ADD:  result = alt ? (op_a - op_b) : (op_a + op_b);
      F3_SLL:  result = op_a << w_shamt;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, op_a < op_b};
      F3_XOR:  result = op_a ^ op_b;
      F3_SR:   result = alt ? XLEN'($signed(op_a) >>> w_shamt) : (op_a >> w_shamt);
      F3_OR:   result = op_a | op_b;
      F3_AND:  result = op_a & op_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_ex_stage.sv
// RV32I execute stage: ALU, branch decision and target, registered toward memory access.
module rv32_ex_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INSN = rv32_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] of_pc,
  input  logic [31:0]     of_instruction,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] immx,
  output logic [XLEN-1:0] aluresult,
  output logic [XLEN-1:0] branch_pc,
  output logic            is_branch_taken,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instruction,
  output logic [XLEN-1:0] ex_op2
);
  import rv32_pkg::*;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_f7_5;
  logic            w_alt;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_y;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_pc_4;
  logic [XLEN-1:0] w_addr;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_br_cond;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_unused;

  assign w_opcode = of_instruction[6:0];
  assign w_funct3 = of_instruction[14:12];
  assign w_f7_5   = of_instruction[30];
  assign w_unused = ^{of_instruction[31], of_instruction[29:15], of_instruction[11:7]};

  // Bit 30 is part of the immediate for I-type, so it only means SRAI there.
  assign w_alt   = (w_opcode == OPC_R) ? w_f7_5 : ((w_funct3 == F3_SR) && w_f7_5);
  assign w_alu_b = (w_opcode == OPC_R) ? op2 : immx;

  rv32_alu #(.XLEN(XLEN)) u_alu (
    .op_a   (op1),
    .op_b   (w_alu_b),
    .funct3 (w_funct3),
    .alt    (w_alt),
    .result (w_alu_y)
  );

  assign w_pc_imm = of_pc + immx;
  assign w_pc_4   = of_pc + XLEN'(4);
  assign w_addr   = op1 + immx;
  assign w_eq     = (op1 == op2);
  assign w_lt     = ($signed(op1) < $signed(op2));
  assign w_ltu    = (op1 < op2);

  always_comb begin
    w_br_cond = 1'b0;
    case (w_funct3)
      F3_BEQ:  w_br_cond = w_eq;
      F3_BNE:  w_br_cond = !w_eq;
      F3_BLT:  w_br_cond = w_lt;
      F3_BGE:  w_br_cond = !w_lt;
      F3_BLTU: w_br_cond = w_ltu;
      F3_BGEU: w_br_cond = !w_ltu;
      default: w_br_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_result = '0;
    w_target = w_pc_imm;
    w_taken  = 1'b0;
    case (w_opcode)
      OPC_R, OPC_I_ALU: w_result = w_alu_y;
      OPC_LD, OPC_ST:   w_result = w_addr;
      OPC_BR:           w_taken  = w_br_cond;
      OPC_JAL: begin
        w_result = w_pc_4;
        w_taken  = 1'b1;
      end
      OPC_JALR: begin
        w_result = w_pc_4;
        w_target = w_addr & ~XLEN'(1);
        w_taken  = 1'b1;
      end
      OPC_LUI:   w_result = immx;
      OPC_AUIPC: w_result = w_pc_imm;
      default: begin
        w_result = '0;
        w_taken  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluresult       <= '0;
      branch_pc       <= '0;
      is_branch_taken <= 1'b0;
      ex_pc           <= '0;
      ex_instruction  <= NOP_INSN;
      ex_op2          <= '0;
    end else if (flush) begin
      aluresult       <= '0;
      branch_pc       <= '0;
      is_branch_taken <= 1'b0;
      ex_pc           <= of_pc;
      ex_instruction  <= NOP_INSN;
      ex_op2          <= '0;
    end else if (!stall) begin
      aluresult       <= w_result;
      branch_pc       <= w_target;
      is_branch_taken <= w_taken;
      ex_pc           <= of_pc;
      ex_instruction  <= of_instruction;
      ex_op2          <= op2;
    end
  end

endmodule

// File: tb/tb_rv32_ex_stage.sv
// Directed-vector bench for rv32_ex_stage with hand-computed expected results.
module tb_rv32_ex_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] of_pc;
  logic [31:0] of_instruction;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] immx;
  logic [31:0] aluresult;
  logic [31:0] branch_pc;
  logic        is_branch_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_instruction;
  logic [31:0] ex_op2;

  int n_total = 0;
  int n_pass  = 0;

  rv32_ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .of_pc           (of_pc),
    .of_instruction  (of_instruction),
    .op1             (op1),
    .op2             (op2),
    .immx            (immx),
    .aluresult       (aluresult),
    .branch_pc       (branch_pc),
    .is_branch_taken (is_branch_taken),
    .ex_pc           (ex_pc),
    .ex_instruction  (ex_instruction),
    .ex_op2          (ex_op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive one vector, clock it, sample 1ns after the edge.
  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    of_instruction = insn;
    of_pc = pc;
    op1 = a;
    op2 = b;
    immx = imm;
    @(posedge clk);
    #1;
    $display("txn stall=%0d flush=%0d insn=%h pc=%h op1=%h op2=%h imm=%h -> alu=%h bpc=%h tk=%0d",
             stall, flush, insn, pc, a, b, imm, aluresult, branch_pc, is_branch_taken);
  endtask

  // Normal cycle: also verifies the pass-through registers.
  task automatic step(input string tag, input logic [31:0] insn, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    drive(insn, pc, a, b, imm);
    check({tag, ".insn"}, ex_instruction, insn);
    check({tag, ".pc"}, ex_pc, pc);
    check({tag, ".op2"}, ex_op2, b);
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    of_pc = '0;
    of_instruction = '0;
    op1 = '0;
    op2 = '0;
    immx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.insn", ex_instruction, 32'h0000_0013);
    check("rst.alu", aluresult, 32'h0);
    check("rst.bpc", branch_pc, 32'h0);
    check("rst.taken", {31'b0, is_branch_taken}, 32'h0);
    check("rst.pc", ex_pc, 32'h0);
    check("rst.op2", ex_op2, 32'h0);
    rst = 1'b1;

    step("add", 32'h0020_81B3, 32'h10, 32'd5, 32'd7, 32'h0);
    check("add.alu", aluresult, 32'd12);
    check("add.taken", {31'b0, is_branch_taken}, 32'h0);

    stall = 1'b1;
    drive(32'h4020_81B3, 32'h14, 32'd100, 32'd1, 32'h0);
    check("stall.alu", aluresult, 32'd12);
    check("stall.insn", ex_instruction, 32'h0020_81B3);
    check("stall.pc", ex_pc, 32'h10);
    check("stall.op2", ex_op2, 32'd7);
    stall = 1'b0;

    step("sub", 32'h4020_81B3, 32'h14, 32'd3, 32'd5, 32'h0);
    check("sub.alu", aluresult, 32'hFFFF_FFFE);
    step("srai", 32'h4040_D193, 32'h18, 32'h8000_0000, 32'h0, 32'h0000_0404);
    check("srai.alu", aluresult, 32'hF800_0000);
    step("srli", 32'h0040_D193, 32'h1C, 32'h8000_0000, 32'h0, 32'h0000_0004);
    check("srli.alu", aluresult, 32'h0800_0000);
    step("addi_neg", 32'hC000_8193, 32'h20, 32'd5, 32'h0, 32'hFFFF_FC00);
    check("addi_neg.alu", aluresult, 32'hFFFF_FC05);
    step("sltu", 32'h0020_B1B3, 32'h24, 32'd5, 32'hFFFF_FFFF, 32'h0);
    check("sltu.alu", aluresult, 32'h1);
    step("slt", 32'h0020_A1B3, 32'h28, 32'd5, 32'hFFFF_FFFF, 32'h0);
    check("slt.alu", aluresult, 32'h0);
    step("xor", 32'h0020_C1B3, 32'h2C, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
    check("xor.alu", aluresult, 32'h0000_0FF0);
    step("or", 32'h0020_E1B3, 32'h30, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
    check("or.alu", aluresult, 32'h0000_FFF0);
    step("and", 32'h0020_F1B3, 32'h34, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
    check("and.alu", aluresult, 32'h0000_F000);
    step("sll", 32'h0020_91B3, 32'h38, 32'h1, 32'h21, 32'h0);
    check("sll.alu", aluresult, 32'h2);
    step("sra", 32'h4020_D1B3, 32'h3C, 32'h8000_0000, 32'h1, 32'h0);
    check("sra.alu", aluresult, 32'hC000_0000);

    step("beq", 32'h0020_8063, 32'h100, 32'd9, 32'd9, 32'd16);
    check("beq.taken", {31'b0, is_branch_taken}, 32'h1);
    check("beq.bpc", branch_pc, 32'h110);
    check("beq.alu", aluresult, 32'h0);

    stall = 1'b1;
    flush = 1'b1;
    drive(32'h0000_00EF, 32'h300, 32'd1, 32'd55, 32'h8);
    check("flush.insn", ex_instruction, 32'h0000_0013);
    check("flush.taken", {31'b0, is_branch_taken}, 32'h0);
    check("flush.alu", aluresult, 32'h0);
    check("flush.bpc", branch_pc, 32'h0);
    check("flush.pc", ex_pc, 32'h300);
    check("flush.op2", ex_op2, 32'h0);
    stall = 1'b0;
    flush = 1'b0;

    step("blt", 32'h0020_C063, 32'h200, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF8);
    check("blt.taken", {31'b0, is_branch_taken}, 32'h0);
    check("blt.bpc", branch_pc, 32'h1F8);
    step("bltu", 32'h0020_E063, 32'h200, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF8);
    check("bltu.taken", {31'b0, is_branch_taken}, 32'h1);
    step("bge", 32'h0020_D063, 32'h204, 32'd5, 32'hFFFF_FFFF, 32'h10);
    check("bge.taken", {31'b0, is_branch_taken}, 32'h1);
    check("bge.bpc", branch_pc, 32'h214);
    step("bne", 32'h0020_9063, 32'h208, 32'd9, 32'd9, 32'h10);
    check("bne.taken", {31'b0, is_branch_taken}, 32'h0);

    step("jalr", 32'h0040_80E7, 32'h40, 32'h201, 32'h0, 32'h4);
    check("jalr.bpc", branch_pc, 32'h204);
    check("jalr.alu", aluresult, 32'h44);
    check("jalr.taken", {31'b0, is_branch_taken}, 32'h1);
    step("jal", 32'h0000_00EF, 32'h80, 32'h0, 32'h0, 32'h100);
    check("jal.bpc", branch_pc, 32'h180);
    check("jal.alu", aluresult, 32'h84);
    check("jal.taken", {31'b0, is_branch_taken}, 32'h1);

    step("lw", 32'h0040_A183, 32'h90, 32'h1000, 32'h0, 32'h4);
    check("lw.alu", aluresult, 32'h1004);
    check("lw.taken", {31'b0, is_branch_taken}, 32'h0);
    step("sw", 32'h0020_A223, 32'h94, 32'h1000, 32'hDEAD_BEEF, 32'h4);
    check("sw.alu", aluresult, 32'h1004);

    step("lui", 32'h1234_52B7, 32'h98, 32'h7, 32'h0, 32'h1234_5000);
    check("lui.alu", aluresult, 32'h1234_5000);
    step("auipc", 32'h1234_5297, 32'h1000, 32'h7, 32'h0, 32'h1234_5000);
    check("auipc.alu", aluresult, 32'h1234_6000);

    step("illegal", 32'h0000_007F, 32'hA0, 32'h3, 32'h4, 32'h5);
    check("illegal.alu", aluresult, 32'h0);
    check("illegal.taken", {31'b0, is_branch_taken}, 32'h0);

    // Asynchronous reset between edges, then the first edge after release is a normal cycle.
    #2;
    rst = 1'b0;
    #1;
    check("arst.insn", ex_instruction, 32'h0000_0013);
    check("arst.pc", ex_pc, 32'h0);
    check("arst.op2", ex_op2, 32'h0);
    rst = 1'b1;
    step("post_rst_add", 32'h0020_81B3, 32'hB0, 32'd5, 32'd7, 32'h0);
    check("post_rst_add.alu", aluresult, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32_ex_stage.md
Name: rv32_ex_stage

Overview:
- Execute stage of the five-stage RV32I pipeline, between operand fetch (OF) and memory access (MA).
- Each clock it takes the decoded instruction, the forwarded operands, the sign-extended immediate and the PC. It computes the ALU result, the branch/jump target and the branch-taken decision.
- It registers these together with the instruction, the PC and the store data for the MA stage.
- It supports stall (hold) and flush (inject bubble) for hazard control.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSN, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected on reset and on flush.

Ports:
- clk  input  1  pipeline clock (rising edge).
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  1 = hold all output registers.
- flush  input  1  1 = replace the current instruction with a bubble.
- of_pc  input  32  PC of the instruction in OF.
- of_instruction  input  32  raw instruction from OF.
- op1  input  32  rs1 value, already forwarded.
- op2  input  32  rs2 value, already forwarded.
- immx  input  32  sign-extended immediate. U-type arrives pre-shifted as {imm[31:12],12'b0}.
- aluresult  output  32  registered ALU / link / address result.
- branch_pc  output  32  registered branch/jump target.
- is_branch_taken  output  1  registered redirect request to IF.
- ex_pc  output  32  registered PC.
- ex_instruction  output  32  registered instruction.
- ex_op2  output  32  registered rs2 value (store data).

Behaviour:
- Reset (rst=0, asynchronous): aluresult=0, branch_pc=0, is_branch_taken=0, ex_pc=0, ex_instruction=NOP_INSN, ex_op2=0.
- Latency: one cycle. All outputs update on the rising clk after inputs are presented. Computation is combinational from the inputs.
- Priority on each edge: flush > stall > normal.
  - flush=1: load the bubble. Outputs match reset values except ex_pc=of_pc.
  - stall=1 (flush=0): all outputs hold.
- Opcode decode (inst[6:0]):
  - R 0110011, funct3/funct7[5]: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Operands op1, op2.
  - I-alu 0010011: same ops on op1 and immx. SUB does not exist here. funct7[5] selects SRAI only when funct3=101. Shift amount is the low 5 bits.
  - Load 0000011 and store 0100011: aluresult = op1+immx.
  - Branch 1100011: branch_pc = pc+immx. Taken condition by funct3:
    - BEQ 000, BNE 001: equality.
    - BLT 100, BGE 101: signed compare.
    - BLTU 110, BGEU 111: unsigned compare.
    - aluresult = 0.
  - JAL 1101111: branch_pc = pc+immx, taken=1, aluresult = pc+4.
  - JALR 1100111: branch_pc = (op1+immx) & ~1, taken=1, aluresult = pc+4.
  - LUI 0110111: aluresult = immx.
  - AUIPC 0010111: aluresult = pc+immx.
  - Any other opcode: aluresult=0, taken=0.
- For non-branch/non-jump opcodes, branch_pc = pc+immx and is don't-care, with taken=0.
- Arithmetic is modulo 2^32 with no overflow flag. SLT/SLTU produce 32'h1 or 32'h0.
- ex_op2 = op2 for every instruction.
- Reset release mid-operation: the first edge with rst=1 behaves as a normal cycle.

Decomposition:
- Shared package rv32_pkg:
  - opcode localparams (R, I_ALU, LD, ST, BR, JAL, JALR, LUI, AUIPC);
  - funct3 codes;
  - NOP_INSN.
- One natural sub-module, rv32_alu: purely combinational, takes op_a, op_b, funct3 and alt bit, returns the result.
- Branch compare and target adders stay in the top module.

Test Plan:
- Reset: hold rst=0 -> ex_instruction=32'h00000013, all other outputs 0, is_branch_taken=0. Release rst, then present add x3,x1,x2 with op1=5, op2=7 -> one edge later aluresult=12, ex_op2=7.
- SUB and SRA: sub with op1=3, op2=5 -> aluresult=32'hFFFFFFFE. srai with op1=32'h80000000, imm=4 -> 32'hF8000000.
- Branch taken vs not taken:
  - beq with op1=op2=9, pc=32'h100, immx=16 -> is_branch_taken=1, branch_pc=32'h110.
  - blt with op1=5, op2=32'hFFFFFFFF -> taken=0.
  - bltu with the same operands -> taken=1.
- JALR: pc=32'h40, op1=32'h201, immx=4 -> branch_pc=32'h204, aluresult=32'h44, taken=1.
- Stall/flush:
  - After a valid add, assert stall with new inputs -> outputs unchanged.
  - Assert stall and flush together -> ex_instruction=NOP_INSN, taken=0, aluresult=0.
- LUI/AUIPC:
  - lui with immx=32'h12345000 -> aluresult=32'h12345000.
  - auipc at pc=32'h1000 with the same immx -> aluresult=32'h12346000.
